// File: rtl/result_uart_tx_if.sv
// ============================================================================
// Module      : result_uart_tx_if
// Description : Handshake/serial bundle between the matrix datapath, the
//               result UART transmitter and the outside world.
//               start      - one-cycle request to send all results
//               RESULT_IN  - result byte from the C-memory read port
//               NEW_OUTPUT - pulse asking the datapath for the next result
//               Show_DATA  - high for the whole transfer (readout enable)
//               TX         - UART serial line, 8N1, LSB first, idle high
//               busy       - transfer in progress
//               done       - one-cycle pulse after the last stop bit
//               master : datapath/controller side
//               slave  : the transmitter
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface result_uart_tx_if;
    logic       start;
    logic [7:0] RESULT_IN;
    logic       NEW_OUTPUT;
    logic       Show_DATA;
    logic       TX;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output RESULT_IN,
        input  NEW_OUTPUT,
        input  Show_DATA,
        input  TX,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  RESULT_IN,
        output NEW_OUTPUT,
        output Show_DATA,
        output TX,
        output busy,
        output done
    );
endinterface

`default_nettype wire

// File: rtl/result_uart_tx.sv
// ============================================================================
// Module      : result_uart_tx
// Description : Streams NUM_RESULTS result bytes from the datapath C memory
//               out of a UART line (8N1, LSB first). For every byte it pulses
//               NEW_OUTPUT, waits two cycles for the synchronous memory read,
//               captures RESULT_IN once, then shifts out start, 8 data and
//               stop bits of CLKS_PER_BIT cycles each.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - result_uart_tx_if.slave (start, RESULT_IN, NEW_OUTPUT,
//                      Show_DATA, TX, busy, done)
// Parameters  : CLKS_PER_BIT - clock cycles per UART bit (4..65535)
//               NUM_RESULTS  - bytes per transfer (1..16)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module result_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_RESULTS  = 9
) (
    input  wire             clk,
    input  wire             rst,
    result_uart_tx_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT      = 3'd2,
        S_LOAD      = 3'd3,
        S_START_BIT = 3'd4,
        S_DATA_BITS = 3'd5,
        S_STOP_BIT  = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    localparam logic [15:0] c_bit_reload = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  c_last_index = 4'(NUM_RESULTS - 1);
    // REQ is followed by exactly two WAIT cycles: load 1, count down to 0.
    localparam logic [15:0] c_wait_load  = 16'd1;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_timer;
    logic [15:0] w_timer_next;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_cnt_next;
    logic [3:0]  r_index;
    logic [3:0]  w_index_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;

    logic        r_tx;
    logic        r_new_output;
    logic        r_show_data;
    logic        r_busy;
    logic        r_done;
    logic        w_tx_next;
    logic        w_new_output_next;
    logic        w_active_next;
    logic        w_done_next;

    logic        w_timer_zero;

    assign w_timer_zero = (r_timer == 16'd0);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_timer   <= 16'd0;
            r_bit_cnt <= 3'd0;
            r_index   <= 4'd0;
            r_shift   <= 8'd0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_index   <= w_index_next;
            r_shift   <= w_shift_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The bit timer counts down and is reloaded at each
    // bit boundary, so each bit is exactly CLKS_PER_BIT cycles and frames
    // never accumulate drift.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_bit_cnt_next = r_bit_cnt;
        w_index_next   = r_index;
        w_shift_next   = r_shift;

        case (r_state)
            S_IDLE: begin
                w_timer_next = 16'd0;
                if (bus.start) begin
                    w_state_next = S_REQ;
                    w_index_next = 4'd0;
                end
            end

            S_REQ: begin
                w_timer_next = c_wait_load;
                w_state_next = S_WAIT;
            end

            S_WAIT: begin
                if (w_timer_zero) begin
                    w_state_next = S_LOAD;
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end

            S_LOAD: begin
                // The only cycle in which RESULT_IN is sampled.
                w_shift_next   = bus.RESULT_IN;
                w_timer_next   = c_bit_reload;
                w_bit_cnt_next = 3'd0;
                w_state_next   = S_START_BIT;
            end

            S_START_BIT: begin
                if (w_timer_zero) begin
                    w_timer_next = c_bit_reload;
                    w_state_next = S_DATA_BITS;
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end

            S_DATA_BITS: begin
                if (w_timer_zero) begin
                    w_timer_next   = c_bit_reload;
                    w_shift_next   = {1'b0, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_STOP_BIT;
                    end
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end

            S_STOP_BIT: begin
                if (w_timer_zero) begin
                    if (r_index == c_last_index) begin
                        w_timer_next = 16'd0;
                        w_state_next = S_DONE;
                    end else begin
                        w_index_next = r_index + 4'd1;
                        w_state_next = S_REQ;
                    end
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end

            S_DONE: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs are decoded from the next state and registered, so they
    // change on the same edge as the state and TX cannot glitch.
    // ------------------------------------------------------------------
    always_comb begin
        w_tx_next         = 1'b1;
        w_new_output_next = 1'b0;
        w_active_next     = 1'b0;
        w_done_next       = 1'b0;

        case (w_state_next)
            S_REQ: begin
                w_new_output_next = 1'b1;
                w_active_next     = 1'b1;
            end
            S_WAIT, S_LOAD, S_STOP_BIT: begin
                w_active_next = 1'b1;
            end
            S_START_BIT: begin
                w_tx_next     = 1'b0;
                w_active_next = 1'b1;
            end
            S_DATA_BITS: begin
                w_tx_next     = w_shift_next[0];
                w_active_next = 1'b1;
            end
            S_DONE: begin
                w_done_next = 1'b1;
            end
            default: begin
                w_tx_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx         <= 1'b1;
            r_new_output <= 1'b0;
            r_show_data  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_tx         <= w_tx_next;
            r_new_output <= w_new_output_next;
            r_show_data  <= w_active_next;
            r_busy       <= w_active_next;
            r_done       <= w_done_next;
        end
    end

    assign bus.TX         = r_tx;
    assign bus.NEW_OUTPUT = r_new_output;
    assign bus.Show_DATA  = r_show_data;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_result_uart_tx.sv
// ============================================================================
// Module      : tb_result_uart_tx
// Description : Self-checking bench for result_uart_tx. A table of transfer
//               scenarios (data source, RESULT_IN noise, stray start pulses,
//               expected pulse counts) is applied in a loop; each cycle of the
//               line and the handshake outputs is compared against a waveform
//               computed from the UART framing rules, and every frame is
//               decoded back to a byte. Hand-written sequences cover reset,
//               mid-frame reset and the full-rate (434) frame length.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_result_uart_tx;

    localparam int C      = 4;
    localparam int N      = 9;
    localparam int FL     = 4 + 10 * C;   // gap (REQ, WAIT x2, LOAD) + frame
    localparam int XFER   = N * FL;       // index of the DONE cycle
    localparam int TAIL   = 12;
    localparam int C_SLOW = 434;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    result_uart_tx_if bus();
    result_uart_tx_if bus_slow();

    result_uart_tx #(.CLKS_PER_BIT(C), .NUM_RESULTS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    result_uart_tx #(.CLKS_PER_BIT(C_SLOW), .NUM_RESULTS(1)) dut_slow (
        .clk (clk),
        .rst (rst),
        .bus (bus_slow)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Datapath C-memory model: the result requested by a NEW_OUTPUT pulse
    // appears two cycles later. In noise mode the bus carries random values
    // in every cycle except the one where the transmitter must capture.
    // ------------------------------------------------------------------
    logic [7:0] mem [N];
    int         ptr   = 0;
    int         cur   = 0;
    int         since = 1000;
    bit         noise = 1'b0;

    initial begin
        bus.RESULT_IN = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (bus.NEW_OUTPUT === 1'b1) begin
                since = 0;
                cur   = (ptr < N) ? ptr : N - 1;
                ptr++;
            end else if (since < 1000) begin
                since++;
            end
            if (noise) begin
                bus.RESULT_IN = (since == 3) ? mem[cur] : 8'($urandom);
            end else if (since == 2) begin
                bus.RESULT_IN = mem[cur];
            end
        end
    end

    // Expected {TX, NEW_OUTPUT, Show_DATA, busy, done} for cycle i after the
    // start pulse is accepted, derived from the framing rules.
    function automatic logic [4:0] expect_cycle(input int i);
        int   k, p, q;
        logic tx, no, act, dn;
        tx = 1'b1; no = 1'b0; act = 1'b0; dn = 1'b0;
        if (i < XFER) begin
            k   = i / FL;
            p   = i % FL;
            act = 1'b1;
            if (p == 0) no = 1'b1;
            if (p >= 4) begin
                q = (p - 4) / C;
                if (q == 0)      tx = 1'b0;
                else if (q <= 8) tx = mem[k][q-1];
            end
        end else if (i == XFER) begin
            dn = 1'b1;
        end
        return {tx, no, act, act, dn};
    endfunction

    task automatic pulse_start();
        @(posedge clk); #2; bus.start = 1'b1;
        @(posedge clk); #2; bus.start = 1'b0;
    endtask

    task automatic run_xfer(input string tag, input int s1, input int s2,
                            input int exp_no, input int exp_done);
        logic [4:0] obs, ex;
        logic       txq [XFER + TAIL];
        logic [7:0] v;
        int         nbad, first_bad, n_no, n_done;
        ptr = 0;
        pulse_start();
        nbad = 0; first_bad = -1; n_no = 0; n_done = 0;
        for (int i = 0; i < XFER + TAIL; i++) begin
            obs    = {bus.TX, bus.NEW_OUTPUT, bus.Show_DATA, bus.busy, bus.done};
            ex     = expect_cycle(i);
            txq[i] = bus.TX;
            if (obs !== ex) begin
                nbad++;
                if (first_bad < 0) first_bad = i;
            end
            if (bus.NEW_OUTPUT === 1'b1) n_no++;
            if (bus.done === 1'b1)       n_done++;
            bus.start = (i == s1 || i == s2) ? 1'b1 : 1'b0;
            @(posedge clk); #2;
        end
        bus.start = 1'b0;
        check($sformatf("%s_wave_bad_cycles(first=%0d)", tag, first_bad), nbad, 0);
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 8; j++) v[j] = txq[k*FL + 4 + C*(1+j) + C/2];
            check($sformatf("%s_byte%0d", tag, k), v, mem[k]);
        end
        check({tag, "_new_output_count"}, n_no, exp_no);
        check({tag, "_done_count"}, n_done, exp_done);
    endtask

    typedef struct {
        int mode;       // 0: all 0xA5, 1: product list, 2: random
        bit noise;      // randomise RESULT_IN outside the capture cycle
        int s1;         // cycle index of a stray start pulse (-1 none)
        int s2;
        int exp_no;
        int exp_done;
    } vec_t;

    vec_t tbl [6];

    task automatic fill_mem(input int mode);
        logic [7:0] prod [N];
        prod = '{8'd30, 8'd36, 8'd42, 8'd66, 8'd81, 8'd96, 8'd102, 8'd126, 8'd150};
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       mem[k] = 8'hA5;
                1:       mem[k] = prod[k];
                default: mem[k] = 8'($urandom);
            endcase
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n, n_done, n_busy, n_txlow, fall, dn;
        logic       sq [$];
        logic [7:0] v;

        rst = 1'b1;
        bus.start = 1'b0;
        bus_slow.start = 1'b0;
        bus_slow.RESULT_IN = 8'h3C;
        fill_mem(0);

        tbl[0] = '{0, 1'b0, -1, -1, N, 1};
        tbl[1] = '{1, 1'b0, -1, -1, N, 1};
        tbl[2] = '{1, 1'b0, 3*FL + 10, XFER, N, 1};
        tbl[3] = '{2, 1'b0, -1, -1, N, 1};
        tbl[4] = '{2, 1'b1, -1, -1, N, 1};
        tbl[5] = '{1, 1'b1, 3*FL + 20, XFER, N, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx", bus.TX, 1);
        check("rst_new_output", bus.NEW_OUTPUT, 0);
        check("rst_show_data", bus.Show_DATA, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_slow_tx", bus_slow.TX, 1);
        rst = 1'b0;
        @(posedge clk); #2;
        check("idle_busy", bus.busy, 0);

        // Table-driven transfers
        for (int t = 0; t < 6; t++) begin
            fill_mem(tbl[t].mode);
            noise = tbl[t].noise;
            run_xfer($sformatf("vec%0d", t), tbl[t].s1, tbl[t].s2,
                     tbl[t].exp_no, tbl[t].exp_done);
            repeat (3) @(posedge clk);
            #2;
        end
        noise = 1'b0;

        // Reset during DATA_BITS of byte 4
        fill_mem(1);
        ptr = 0;
        pulse_start();
        n = 4*FL + 4 + C + 5;
        repeat (n) @(posedge clk);
        #2;
        check("midrst_busy_before", bus.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_tx", bus.TX, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_show_data", bus.Show_DATA, 0);
        check("midrst_done", bus.done, 0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        n_done = 0; n_busy = 0; n_txlow = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (bus.done === 1'b1) n_done++;
            if (bus.busy !== 1'b0) n_busy++;
            if (bus.TX !== 1'b1)   n_txlow++;
        end
        check("postrst_done_count", n_done, 0);
        check("postrst_busy_cycles", n_busy, 0);
        check("postrst_tx_low_cycles", n_txlow, 0);
        fill_mem(2);
        run_xfer("after_rst", -1, -1, N, 1);

        // Full-rate single frame on the second instance
        @(posedge clk); #2; bus_slow.start = 1'b1;
        @(posedge clk); #2; bus_slow.start = 1'b0;
        fall = -1; dn = -1;
        for (int i = 0; i < 6000 && dn < 0; i++) begin
            sq.push_back(bus_slow.TX);
            if (fall < 0 && bus_slow.TX === 1'b0) fall = i;
            if (bus_slow.done === 1'b1)           dn = i;
            @(posedge clk); #2;
        end
        check("slow_latency", fall + 1, 5);
        check("slow_frame_cycles", dn - fall, 10 * C_SLOW);
        v = 8'h00;
        for (int j = 0; j < 8; j++) begin
            n = fall + C_SLOW*(1+j) + C_SLOW/2;
            if (fall >= 0 && n < sq.size()) v[j] = sq[n];
        end
        check("slow_byte", v, 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, meaning CLK cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 Parameter NUM_RESULTS, default 9, meaning number of 8-bit results per matrix product (3x3 C matrix).
REQ-003 CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins a transfer of NUM_RESULTS results; ignored unless idle.
REQ-006 RESULT_IN  input  8  result byte from datapath C memory read port.
REQ-007 NEW_OUTPUT  output  1  one-cycle pulse requesting the datapath to advance to the next result.
REQ-008 Show_DATA  output  1  held high for the whole transfer; enables datapath readout counter.
REQ-009 TX  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-010 busy  output  1  high from accepted start until the final stop bit completes.
REQ-011 done  output  1  one-cycle pulse after the final stop bit of byte NUM_RESULTS-1.

Function
REQ-012 FSM states: IDLE, REQ, WAIT, LOAD, START_BIT, DATA_BITS, STOP_BIT, DONE.
REQ-013 IDLE: TX=1, busy=0, Show_DATA=0; start=1 -> REQ, byte index cleared to 0.
REQ-014 REQ (1 cycle): NEW_OUTPUT=1, Show_DATA=1 -> WAIT.
REQ-015 WAIT (exactly 2 cycles, covering synchronous memory read latency) -> LOAD.
REQ-016 LOAD (1 cycle): RESULT_IN captured into 8-bit shift register -> START_BIT; RESULT_IN is not sampled in any other state.
REQ-017 START_BIT: TX=0 for CLKS_PER_BIT cycles -> DATA_BITS.
REQ-018 DATA_BITS: TX = shift register bit 0, each bit held CLKS_PER_BIT cycles, shift right after each bit; 8 bits, then -> STOP_BIT.
REQ-019 STOP_BIT: TX=1 for CLKS_PER_BIT cycles; then, if byte index = NUM_RESULTS-1 -> DONE, else index+1 -> REQ.
REQ-020 DONE (1 cycle): done=1, Show_DATA=0, busy=0 -> IDLE.
REQ-021 Latency: from start pulse to TX falling edge = 5 cycles (IDLE->REQ->WAIT x2->LOAD->START_BIT).
REQ-022 Inter-byte gap: 4 cycles of TX=1 beyond the stop bit (REQ, WAIT x2, LOAD).
REQ-023 Bit timer: 16-bit down/up counter, reloads on every bit boundary; no cumulative drift; frame = 10*CLKS_PER_BIT cycles exactly.
REQ-024 Byte index: 4-bit counter, wraps to 0 only via IDLE; never exceeds NUM_RESULTS-1.
REQ-025 start while busy: ignored, no effect on index, timer or TX.
REQ-026 start in the DONE cycle: ignored; a new start is accepted only in IDLE.
REQ-027 NEW_OUTPUT is asserted exactly NUM_RESULTS times per transfer, never outside REQ.
REQ-028 All outputs registered; TX glitch-free.

Reset
REQ-029 RST=1 forces immediately: state=IDLE, TX=1, NEW_OUTPUT=0, Show_DATA=0, busy=0, done=0, index=0, timer=0, shift register=0.
REQ-030 RST asserted mid-frame aborts the frame; TX returns high asynchronously; no done pulse; after release the block waits for a new start.

Verification
REQ-031 CLKS_PER_BIT=4, RESULT_IN=0xA5 for all reads, start pulse -> TX low at cycle 5, bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles.
REQ-032 Full transfer, RESULT_IN model returns 8'd30,36,42,66,81,96,102,126,150 two cycles after each NEW_OUTPUT -> nine frames decoded in that order, nine NEW_OUTPUT pulses, one done pulse, busy falls with done.
REQ-033 start pulses during byte 3 and in the DONE cycle -> ignored; exactly nine frames, no second transfer.
REQ-034 RST pulse during DATA_BITS of byte 4 -> TX=1 same cycle, busy=0, Show_DATA=0, no done; subsequent start transmits from byte 0.
REQ-035 CLKS_PER_BIT=434 single frame -> start-bit falling edge to stop-bit end measures exactly 4340 cycles.
REQ-036 RESULT_IN changed in cycles other than LOAD -> transmitted bytes reflect only the LOAD-cycle value.
